// File: rtl/uart_pkg.sv
// Shared encodings for the oversampling UART receiver.
// Parity modes and receive FSM states.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rd_dat whenever !empty.
// Latency: a write is visible at the head one cycle later; reads take effect on the clock edge.
// Backpressure: writes are refused when full unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd  = rd_rdy & ~empty;
    // A read frees the slot the write lands in, so full does not block a same-cycle write.
    assign do_wr  = wr_vld & (~full | do_rd);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// Oversampling UART receiver delivering {parity_err, frame_err, data} words through a FIFO.
// Latency: word is pushed on the final stop-bit sample; o_valid rises the following cycle.
// Backpressure: o_valid/i_ready drain; a push into a full FIFO is dropped and sets sticky o_overrun.
module uart_rx_monitor #(
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_line,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    input  logic                 i_clr_overrun
);

    import uart_pkg::*;

    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CTR_HALF  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CTR_LAST  = CW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic                 sync1;
    logic                 ln;
    rx_state_t            state;
    logic [CW-1:0]        ctr;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;

    logic                 push;
    logic [DATA_BITS+1:0] push_dat;
    logic [DATA_BITS+1:0] head_dat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            ln    <= 1'b1;
        end else begin
            sync1 <= i_line;
            ln    <= sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            ctr     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ctr <= '0;
                    if (!ln) state <= S_START;
                end
                S_START: begin
                    if (ctr == CTR_HALF) begin
                        ctr     <= '0;
                        bit_idx <= '0;
                        par_err <= 1'b0;
                        frm_err <= 1'b0;
                        state   <= ln ? S_IDLE : S_DATA;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                S_DATA: begin
                    if (ctr == CTR_LAST) begin
                        ctr   <= '0;
                        shreg <= {ln, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (ctr == CTR_LAST) begin
                        ctr     <= '0;
                        par_err <= (PARITY == PAR_ODD) ? ~(^shreg ^ ln) : (^shreg ^ ln);
                        state   <= S_STOP;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                S_STOP: begin
                    if (ctr == CTR_LAST) begin
                        ctr     <= '0;
                        frm_err <= frm_err | ~ln;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            // A low final stop bit means the line may be held in break.
                            state   <= ln ? S_IDLE : S_BREAK;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (ln) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The last stop sample is folded in here so the word can be pushed on the sample cycle itself.
    assign push     = (state == S_STOP) && (ctr == CTR_LAST) && (bit_idx == STOP_LAST);
    assign push_dat = {par_err, frm_err | ~ln, shreg};
    assign pop      = ~fifo_empty & i_ready;

    sync_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .core_clk(i_clk),
        .arst_n  (i_rst_n),
        .wr_vld  (push),
        .wr_dat  (push_dat),
        .rd_rdy  (i_ready),
        .rd_dat  (head_dat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_parity_err = head_dat[DATA_BITS+1];
    assign o_frame_err  = head_dat[DATA_BITS];
    assign o_data       = head_dat[DATA_BITS-1:0];
    assign o_valid      = ~fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (i_clr_overrun) begin
            o_overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            o_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: an 8N1 instance and an 8E1 instance, scoreboard-checked words.
module tb_uart_rx_monitor;

    localparam int OVS = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       line_a = 1'b1, line_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic       clr_a = 1'b0, clr_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       ferr_a, ferr_b, perr_a, perr_b, valid_a, valid_b, ovr_a, ovr_b;

    always #5 clk = ~clk;

    uart_rx_monitor #(.OVS(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_line(line_a), .o_data(data_a),
        .o_frame_err(ferr_a), .o_parity_err(perr_a), .o_valid(valid_a),
        .i_ready(ready_a), .o_overrun(ovr_a), .i_clr_overrun(clr_a)
    );

    uart_rx_monitor #(.OVS(OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_line(line_b), .o_data(data_b),
        .o_frame_err(ferr_b), .o_parity_err(perr_b), .o_valid(valid_b),
        .i_ready(ready_b), .o_overrun(ovr_b), .i_clr_overrun(clr_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        bit         sel_b;
        logic [7:0] data;
        logic       par_bit;
        logic       stop;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    vec_t vecs[9];
    int   total  = 0;
    int   bad    = 0;
    int   vcnt_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input bit sel_b, input logic v);
        if (sel_b) line_b = v;
        else       line_a = v;
        cyc(OVS);
    endtask

    task automatic send(input bit sel_b, input logic [7:0] d, input logic par_bit, input logic stop);
        drive_bit(sel_b, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel_b, d[i]);
        if (sel_b) drive_bit(sel_b, par_bit);
        drive_bit(sel_b, stop);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin
            cyc(1);
            n++;
        end
        check(name, 32'(qa.size() + qb.size()), 32'd0);
    endtask

    // Scoreboard: every accepted word is compared against the oldest expectation.
    always @(negedge clk) begin
        if (valid_a) vcnt_a++;
        if (rst_n && valid_a && ready_a) begin
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_word actual=%0h required=none", data_a);
            end else begin
                ea = qa.pop_front();
                check("a_data", 32'(data_a), 32'(ea.data));
                check("a_frame_err", 32'(ferr_a), 32'(ea.ferr));
                check("a_parity_err", 32'(perr_a), 32'(ea.perr));
            end
        end
        if (rst_n && valid_b && ready_b) begin
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_word actual=%0h required=none", data_b);
            end else begin
                eb = qb.pop_front();
                check("b_data", 32'(data_b), 32'(eb.data));
                check("b_frame_err", 32'(ferr_b), 32'(eb.ferr));
                check("b_parity_err", 32'(perr_b), 32'(eb.perr));
            end
        end
    end

    initial begin
        // sel_b, data, parity bit, stop bit, expected frame_err, expected parity_err (even parity on b)
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0};

        cyc(3);
        @(negedge clk);
        check("rst_a_valid", 32'(valid_a), 32'd0);
        check("rst_a_data", 32'(data_a), 32'd0);
        check("rst_a_frame_err", 32'(ferr_a), 32'd0);
        check("rst_a_parity_err", 32'(perr_a), 32'd0);
        check("rst_a_overrun", 32'(ovr_a), 32'd0);
        check("rst_b_valid", 32'(valid_b), 32'd0);
        check("rst_b_data", 32'(data_b), 32'd0);
        check("rst_b_overrun", 32'(ovr_b), 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(4);

        // Single 8N1 frame, valid for exactly one cycle with ready held high.
        vcnt_a = 0;
        qa.push_back('{8'hA5, 1'b0, 1'b0});
        send(1'b0, 8'hA5, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        check("a5_valid_cycles", 32'(vcnt_a), 32'd1);

        // Short low glitch is a false start.
        vcnt_a = 0;
        line_a = 1'b0;
        cyc(5);
        line_a = 1'b1;
        cyc(60);
        check("glitch_valid_cycles", 32'(vcnt_a), 32'd0);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].sel_b) qb.push_back('{vecs[v].data, vecs[v].exp_ferr, vecs[v].exp_perr});
            else               qa.push_back('{vecs[v].data, vecs[v].exp_ferr, vecs[v].exp_perr});
            send(vecs[v].sel_b, vecs[v].data, vecs[v].par_bit, vecs[v].stop);
            drive_bit(vecs[v].sel_b, 1'b1);
            drive_bit(vecs[v].sel_b, 1'b1);
        end
        wait_drain("table_drain");

        // Low stop bit followed by a long break: one errored word only.
        vcnt_a = 0;
        qa.push_back('{8'h81, 1'b1, 1'b0});
        send(1'b0, 8'h81, 1'b0, 1'b0);
        cyc(40 * OVS);
        check("break_word_count", 32'(vcnt_a), 32'd1);
        line_a = 1'b1;
        cyc(2 * OVS);
        qa.push_back('{8'h55, 1'b0, 1'b0});
        send(1'b0, 8'h55, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        wait_drain("break_recover_drain");

        // Fill past depth with ready low; fifth word must be dropped.
        ready_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) qa.push_back('{8'(k), 1'b0, 1'b0});
            send(1'b0, 8'(k), 1'b0, 1'b1);
            drive_bit(1'b0, 1'b1);
        end
        @(negedge clk);
        check("overrun_set", 32'(ovr_a), 32'd1);
        check("overrun_head_valid", 32'(valid_a), 32'd1);
        cyc(1);
        vcnt_a  = 0;
        ready_a = 1'b1;
        cyc(10);
        check("drain_no_bubble", 32'(vcnt_a), 32'd4);
        check("drain_empty", 32'(qa.size()), 32'd0);
        check("overrun_sticky", 32'(ovr_a), 32'd1);
        clr_a = 1'b1;
        cyc(1);
        clr_a = 1'b0;
        @(negedge clk);
        check("overrun_cleared", 32'(ovr_a), 32'd0);
        cyc(1);

        // Reset in the middle of a frame while another word sits in the FIFO.
        ready_a = 1'b0;
        send(1'b0, 8'h77, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        @(negedge clk);
        check("pre_reset_valid", 32'(valid_a), 32'd1);
        cyc(1);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1);
        line_a = 1'b0;
        cyc(OVS / 2);
        rst_n  = 1'b0;
        line_a = 1'b1;
        cyc(2);
        @(negedge clk);
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_data", 32'(data_a), 32'd0);
        check("midrst_frame_err", 32'(ferr_a), 32'd0);
        check("midrst_parity_err", 32'(perr_a), 32'd0);
        check("midrst_overrun", 32'(ovr_a), 32'd0);
        cyc(1);
        rst_n   = 1'b1;
        ready_a = 1'b1;
        vcnt_a  = 0;
        cyc(6 * OVS);
        check("midrst_no_word", 32'(vcnt_a), 32'd0);
        qa.push_back('{8'h3C, 1'b0, 1'b0});
        send(1'b0, 8'h3C, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        wait_drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
